input_data: RTL and testbench

Operator-input controller for the processing unit: the producer-side counterpart of the display output path. It debounces the raw "enter" push-button, samples the data switches on each accepted press, and queues the sampled word in a 2-entry buffer. The processor pops the buffer when it executes an input instruction. The processor is stalled while an input instruction waits on an empty buffer.

---
 rtl/input_data_if.sv | 25 ++
 rtl/input_data.sv | 116 +++++++++++
 tb/tb_input_data.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/input_data_if.sv
// Operator-input bus: raw switch/button levels and the processor read handshake.
interface input_data_if #(
    parameter int unsigned SWITCH_WIDTH = 16
);
    logic [SWITCH_WIDTH-1:0] switches;
    logic                    enter_button;
    logic                    read_request;
    logic [31:0]             data_output;
    logic                    data_valid;
    logic                    stall;
    logic                    overrun;
    logic [1:0]              buffer_count;

    // Operator/processor side drives the raw inputs and the read request.
    modport master (
        output switches, enter_button, read_request,
        input  data_output, data_valid, stall, overrun, buffer_count
    );

    // Controller side.
    modport slave (
        input  switches, enter_button, read_request,
        output data_output, data_valid, stall, overrun, buffer_count
    );
endinterface

// File: rtl/input_data.sv
// Operator-input controller: debounces the enter button, samples the switches on
// each accepted press and queues the word in a 2-entry FIFO popped by the processor.
module input_data #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SWITCH_WIDTH    = 16
) (
    input logic          clock,
    input logic          reset,
    input_data_if.slave  bus
);
    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                    btn_sync1_q, btn_sync1_d;
    logic                    btn_sync2_q, btn_sync2_d;
    logic [SWITCH_WIDTH-1:0] sw_sync1_q, sw_sync1_d;
    logic [SWITCH_WIDTH-1:0] sw_sync2_q, sw_sync2_d;
    logic                    stable_q, stable_d;
    logic                    stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0]        db_count_q, db_count_d;
    logic                    capture_q, capture_d;
    logic [SWITCH_WIDTH-1:0] mem_q [2];
    logic [SWITCH_WIDTH-1:0] mem_d [2];
    logic                    head_q, head_d;
    logic                    tail_q, tail_d;
    logic [1:0]              count_q, count_d;
    logic                    overrun_q, overrun_d;

    logic                    pop_c;
    logic                    push_c;
    logic [SWITCH_WIDTH-1:0] head_word_c;

    // Next-state: synchronizers, debounce, edge detect and FIFO bookkeeping.
    always_comb begin
        btn_sync1_d  = bus.enter_button;
        btn_sync2_d  = btn_sync1_q;
        sw_sync1_d   = bus.switches;
        sw_sync2_d   = sw_sync1_q;
        stable_d     = stable_q;
        db_count_d   = db_count_q;
        stable_dly_d = stable_q;
        capture_d    = stable_q & ~stable_dly_q;
        mem_d        = mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        overrun_d    = overrun_q;

        // Any return to the accepted level restarts the stability count.
        if (btn_sync2_q == stable_q) begin
            db_count_d = '0;
        end else if (db_count_q == DB_LAST) begin
            stable_d   = btn_sync2_q;
            db_count_d = '0;
        end else begin
            db_count_d = db_count_q + CNT_W'(1);
        end

        pop_c  = bus.read_request && (count_q != 2'd0);
        push_c = capture_q && ((count_q != 2'd2) || pop_c);

        if (push_c) begin
            mem_d[tail_q] = sw_sync2_q;
            tail_d        = ~tail_q;
        end
        if (capture_q && !push_c) begin
            overrun_d = 1'b1;
        end
        if (pop_c) begin
            head_d = ~head_q;
        end
        count_d = count_q + 2'(push_c) - 2'(pop_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_sync1_q  <= 1'b0;
            btn_sync2_q  <= 1'b0;
            sw_sync1_q   <= '0;
            sw_sync2_q   <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_count_q   <= '0;
            capture_q    <= 1'b0;
            mem_q        <= '{default: '0};
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            count_q      <= 2'd0;
            overrun_q    <= 1'b0;
        end else begin
            btn_sync1_q  <= btn_sync1_d;
            btn_sync2_q  <= btn_sync2_d;
            sw_sync1_q   <= sw_sync1_d;
            sw_sync2_q   <= sw_sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            db_count_q   <= db_count_d;
            capture_q    <= capture_d;
            mem_q        <= mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
        end
    end

    // Head entry is presented combinationally so the processor consumes it in the pop cycle.
    assign head_word_c      = mem_q[head_q];
    assign bus.data_output  = (count_q == 2'd0) ? '0 : DATA_W'(signed'(head_word_c));
    assign bus.data_valid   = (count_q != 2'd0);
    assign bus.buffer_count = count_q;
    assign bus.overrun      = overrun_q;
    assign bus.stall        = !reset && bus.read_request && (count_q == 2'd0);

endmodule

// File: tb/tb_input_data.sv
// Directed self-checking bench for input_data with a 4-cycle debounce window.
module tb_input_data;
    localparam int unsigned D  = 4;
    localparam int unsigned SW = 16;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    input_data_if #(.SWITCH_WIDTH(SW)) bus ();

    input_data #(.DEBOUNCE_CYCLES(D), .SWITCH_WIDTH(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
    endtask

    // Clean press held long enough to be accepted, then a debounced release.
    task automatic press(input logic [SW-1:0] v);
        bus.switches     = v;
        bus.enter_button = 1'b1;
        step(10);
        bus.enter_button = 1'b0;
        step(10);
    endtask

    // Press with read_request high exactly at the push edge (push and pop together).
    task automatic press_with_read(input logic [SW-1:0] v);
        bus.switches     = v;
        bus.enter_button = 1'b1;
        step(7);
        bus.read_request = 1'b1;
        step(1);
        bus.read_request = 1'b0;
    endtask

    task automatic read_one();
        bus.read_request = 1'b1;
        step(1);
        bus.read_request = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset            = 1'b1;
        bus.switches     = '0;
        bus.enter_button = 1'b0;
        bus.read_request = 1'b0;
        step(1);
        do_reset();

        // 1. reset idle
        check("rst_data",    bus.data_output,         32'h0);
        check("rst_valid",   32'(bus.data_valid),     32'd0);
        check("rst_count",   32'(bus.buffer_count),   32'd0);
        check("rst_overrun", 32'(bus.overrun),        32'd0);
        check("rst_stall",   32'(bus.stall),          32'd0);

        // 2. single press: push lands on the D+3'th edge after the sampling edge
        bus.switches     = 16'hFFFE;
        bus.enter_button = 1'b1;
        step(7);
        check("sp_valid_early", 32'(bus.data_valid),   32'd0);
        step(1);
        check("sp_valid",       32'(bus.data_valid),   32'd1);
        check("sp_data",        bus.data_output,       32'hFFFF_FFFE);
        check("sp_count",       32'(bus.buffer_count), 32'd1);
        bus.enter_button = 1'b0;
        read_one();
        check("sp_pop_count",   32'(bus.buffer_count), 32'd0);
        check("sp_pop_data",    bus.data_output,       32'h0);
        step(10);
        check("sp_release",     32'(bus.buffer_count), 32'd0);

        // 3. bounce rejection, then one clean press
        bus.switches     = 16'h00A5;
        bus.enter_button = 1'b1; step(3);
        bus.enter_button = 1'b0; step(1);
        bus.enter_button = 1'b1; step(3);
        bus.enter_button = 1'b0; step(10);
        check("bounce_count",  32'(bus.buffer_count), 32'd0);
        press(16'h00A5);
        check("clean_count",   32'(bus.buffer_count), 32'd1);
        check("clean_data",    bus.data_output,       32'h0000_00A5);
        read_one();
        check("clean_drain",   32'(bus.buffer_count), 32'd0);

        // 4. stall while waiting on an empty buffer
        bus.read_request = 1'b1;
        step(2);
        check("stall_idle",    32'(bus.stall), 32'd1);
        bus.switches     = 16'h0005;
        bus.enter_button = 1'b1;
        step(7);
        check("stall_push_cyc", 32'(bus.stall),        32'd1);
        step(1);
        check("stall_after",    32'(bus.stall),        32'd0);
        check("stall_data",     bus.data_output,       32'h0000_0005);
        check("stall_count",    32'(bus.buffer_count), 32'd1);
        step(1);
        bus.read_request = 1'b0;
        check("stall_popped",   32'(bus.buffer_count), 32'd0);
        bus.enter_button = 1'b0;
        step(10);

        // 5. overrun on a third press with no reads
        press(16'd1);
        press(16'd2);
        press(16'd3);
        check("ovr_count", 32'(bus.buffer_count), 32'd2);
        check("ovr_flag",  32'(bus.overrun),      32'd1);
        check("ovr_head",  bus.data_output,       32'd1);
        read_one();
        check("ovr_rd2",   bus.data_output,       32'd2);
        read_one();
        check("ovr_empty", 32'(bus.buffer_count), 32'd0);
        check("ovr_stick", 32'(bus.overrun),      32'd1);
        do_reset();
        check("ovr_clear", 32'(bus.overrun),      32'd0);

        // 7. simultaneous push/pop at count 1 and count 2
        press(16'h0011);
        press_with_read(16'h0022);
        check("pp1_count", 32'(bus.buffer_count), 32'd1);
        check("pp1_head",  bus.data_output,       32'h0000_0022);
        bus.enter_button = 1'b0;
        step(10);
        press(16'h0033);
        check("pp2_fill",  32'(bus.buffer_count), 32'd2);
        press_with_read(16'h0044);
        check("pp2_count", 32'(bus.buffer_count), 32'd2);
        check("pp2_ovr",   32'(bus.overrun),      32'd0);
        check("pp2_head",  bus.data_output,       32'h0000_0033);
        bus.enter_button = 1'b0;
        step(10);
        read_one();
        check("pp2_next",  bus.data_output,       32'h0000_0044);
        do_reset();

        // 6. reset mid-debounce discards the press; held button re-debounces from zero
        bus.switches     = 16'h8001;
        bus.enter_button = 1'b1;
        step(4);
        reset            = 1'b1;
        bus.read_request = 1'b1;
        step(1);
        check("rst_stall_forced", 32'(bus.stall), 32'd0);
        step(1);
        bus.read_request = 1'b0;
        reset            = 1'b0;
        step(7);
        check("rmid_none",  32'(bus.buffer_count), 32'd0);
        step(1);
        check("rmid_one",   32'(bus.buffer_count), 32'd1);
        check("rmid_data",  bus.data_output,       32'hFFFF_8001);
        step(10);
        check("rmid_held",  32'(bus.buffer_count), 32'd1);
        bus.enter_button = 1'b0;
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
